// File: rtl/retire_timer_ctrl.sv
// retire_timer_ctrl: memory-mapped controller for the 64-bit retire-driven timer.
// Owns mtime/mtimecmp. 64-bit values cross the 32-bit register bus as a lo write into a
// staging register followed by a hi write that commits both halves on one edge.
// Reading MTIME_LO snapshots the upper half so that a following MTIME_HI read is tear-free.
//
// Optional build macro: TIMER_PRESCALE_EN adds a PRESCALE divider at offset 0x18.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick_in       one count event per cycle (instruction retired / atomic completing)
//   req_*         register bus request (valid/ready, write, byte addr, wdata, wmask)
//   resp_*        one-cycle response pulse with read data and unmapped-address error
//   mtime_o       current 64-bit count
//   irq           registered timer interrupt level
module retire_timer_ctrl #(
  parameter logic [63:0] RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mtime_o,
  output logic        irq
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;
  state_e state_q, state_d;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] mstage_q, mstage_d;   // MTIME_LO staging
  logic [31:0] cstage_q, cstage_d;   // CMP_LO staging
  logic [31:0] shadow_q, shadow_d;   // mtime[63:32] snapshot taken on MTIME_LO read
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;

  logic        accept;
  logic [2:0]  word;
  logic        cnt_en, irq_en, match, count_tick;

  assign accept = req_valid & req_ready;
  assign word   = req_addr[4:2];
  assign cnt_en = ctrl_q[0];
  assign irq_en = ctrl_q[1];
  assign match  = mtime_q >= cmp_q;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic                  prescale_wr;
  logic [31:0]           prescale_merged;

  assign prescale_wr     = accept & req_write & (word == 3'd6);
  assign count_tick      = tick_in & (div_q == prescale_q);
  assign prescale_merged = merge(32'(prescale_q), req_wdata, req_wmask);

  always_comb begin
    prescale_d = prescale_q;
    div_d      = div_q;
    if (prescale_wr) begin
      prescale_d = prescale_merged[PRESCALE_W-1:0];
    end
    if (!cnt_en || prescale_wr) begin
      div_d = '0;
    end else if (tick_in) begin
      div_d = count_tick ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
      div_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      div_q      <= div_d;
    end
  end
`else
  assign count_tick = tick_in;
`endif

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
  end

  // Datapath next state; a hi commit is applied after the count so it wins on the same edge.
  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    mstage_d = mstage_q;
    cstage_d = cstage_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    irq_d    = irq_en & match;

    if (cnt_en && count_tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (accept) begin
      rdata_d = '0;
      err_d   = 1'b0;
      if (req_write) begin
        case (word)
          3'd0: mstage_d = merge(mstage_q, req_wdata, req_wmask);
          3'd1: mtime_d  = {merge(mtime_q[63:32], req_wdata, req_wmask), mstage_q};
          3'd2: cstage_d = merge(cstage_q, req_wdata, req_wmask);
          3'd3: cmp_d    = {merge(cmp_q[63:32], req_wdata, req_wmask), cstage_q};
          3'd4: begin
            ctrl_d = merge({30'd0, ctrl_q}, req_wdata, req_wmask) & 32'h3;
          end
          3'd7: err_d = 1'b1;
          default: ;
        endcase
      end else begin
        case (word)
          3'd0: begin
            rdata_d  = mtime_q[31:0];
            shadow_d = mtime_q[63:32];
          end
          3'd1: rdata_d = shadow_q;
          3'd2: rdata_d = cmp_q[31:0];
          3'd3: rdata_d = cmp_q[63:32];
          3'd4: rdata_d = {30'd0, ctrl_q};
          3'd5: rdata_d = {31'd0, match};
`ifdef TIMER_PRESCALE_EN
          3'd6: rdata_d = 32'(prescale_q);
`endif
          3'd7: err_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      cmp_q    <= RESET_CMP;
      mstage_q <= '0;
      cstage_q <= '0;
      shadow_q <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      mstage_q <= mstage_d;
      cstage_q <= cstage_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mtime_o    = mtime_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_retire_timer_ctrl.sv
module tb_retire_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mtime_o;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  retire_timer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mtime_o    (mtime_o),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; expected response is queued when driven, checked when it appears.
  task automatic do_req(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic tick,
                        input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    tick_in   = tick;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    check("ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tick_in   = 1'b0;
    @(negedge clk);
    check("ready_busy", req_ready, 0);
    check("resp_valid", resp_valid, 1);
    e = sb.pop_front();
    if (resp_valid) begin
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", resp_err, e.err);
    end
  endtask

  task automatic ticks(input int n);
    @(negedge clk);
    tick_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick_in = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_irq", irq, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mtime", mtime_o, 64'd0);
    do_req(0, 5'h10, 0, 0, 0, 32'h0, 0);
    do_req(0, 5'h00, 0, 0, 0, 32'h0, 0);
    do_req(0, 5'h0C, 0, 0, 0, 32'hFFFF_FFFF, 0);

    // Counting with enable
    do_req(1, 5'h10, 32'h1, 4'hF, 0, 32'h0, 0);
    ticks(10);
    do_req(0, 5'h00, 0, 0, 0, 32'd10, 0);
    repeat (5) @(negedge clk);
    do_req(0, 5'h00, 0, 0, 0, 32'd10, 0);

    // Atomic commit and tear-free read
    do_req(1, 5'h00, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h04, 32'h0, 4'hF, 0, 32'h0, 0);
    check("commit_mtime", mtime_o, 64'h0000_0000_FFFF_FFFF);
    ticks(1);
    do_req(0, 5'h00, 0, 0, 0, 32'h0, 0);
    do_req(0, 5'h04, 0, 0, 0, 32'h1, 0);
    ticks(5);
    do_req(0, 5'h04, 0, 0, 0, 32'h1, 0);
    check("mtime_after_ticks", mtime_o, 64'h1_0000_0005);

    // Interrupt rise and fall
    do_req(1, 5'h08, 32'd20, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h0C, 32'd0, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h00, 32'd0, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h04, 32'd0, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h10, 32'h3, 4'hF, 0, 32'h0, 0);
    check("irq_before", irq, 0);
    ticks(20);
    @(negedge clk);
    check("mtime_at_cmp", mtime_o, 64'd20);
    check("irq_lag", irq, 0);
    @(negedge clk);
    check("irq_rise", irq, 1);
    do_req(0, 5'h14, 0, 0, 0, 32'h1, 0);
    do_req(1, 5'h0C, 32'h1, 4'hF, 0, 32'h0, 0);
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_fall", irq, 0);
    do_req(0, 5'h14, 0, 0, 0, 32'h0, 0);

    // Byte-masked hi write keeps unmasked bytes
    do_req(1, 5'h0C, 32'hAAAA_CDAA, 4'b0010, 0, 32'h0, 0);
    do_req(0, 5'h0C, 0, 0, 0, 32'h0000_CD01, 0);
    do_req(0, 5'h08, 0, 0, 0, 32'd20, 0);

    // Unmapped address and commit-vs-tick priority
    do_req(0, 5'h1C, 0, 0, 0, 32'h0, 1);
    do_req(1, 5'h1C, 32'h1234, 4'hF, 0, 32'h0, 1);
    do_req(1, 5'h00, 32'h55, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h04, 32'h2, 4'hF, 1, 32'h0, 0);
    check("commit_beats_tick", mtime_o, 64'h2_0000_0055);

`ifdef TIMER_PRESCALE_EN
    do_req(1, 5'h18, 32'd3, 4'hF, 0, 32'h0, 0);
    do_req(0, 5'h18, 0, 0, 0, 32'd3, 0);
    do_req(1, 5'h00, 32'd0, 4'hF, 0, 32'h0, 0);
    do_req(1, 5'h04, 32'd0, 4'hF, 0, 32'h0, 0);
    ticks(12);
    @(negedge clk);
    check("prescale_mtime", mtime_o, 64'd3);
`else
    do_req(1, 5'h18, 32'd3, 4'hF, 0, 32'h0, 0);
    do_req(0, 5'h18, 0, 0, 0, 32'h0, 0);
`endif

    // Reset during a request drops it and loses staging
    do_req(1, 5'h00, 32'h1234, 4'hF, 0, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'h08;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_resp", resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_resp2", resp_valid, 0);
    check("rst_mid_irq", irq, 0);
    check("rst_mid_mtime", mtime_o, 64'd0);
    do_req(1, 5'h04, 32'h0, 4'hF, 0, 32'h0, 0);
    check("stage_lost", mtime_o, 64'd0);
    do_req(0, 5'h08, 0, 0, 0, 32'hFFFF_FFFF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
